// File: rtl/uart_dbg_loader.sv
// Byte-command debug front end: parses host commands from the UART and drives
// the debug memory port and the CPU reset.
module uart_dbg_loader #(
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    output logic        cpu_n_reset
);

    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MEM, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] adr_sh_q, adr_sh_d;
    logic [31:0] dat_sh_q, dat_sh_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] resp_q, resp_d;
    logic        tx_valid_q, tx_valid_d;
    logic        mem_op_q, mem_op_d;
    logic [3:0]  wren_q, wren_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] do_q, do_d;
    logic        cpu_q, cpu_d;
    logic [31:0] adr_full, dat_full;

    // Field values including the byte arriving this cycle (fields are LSB first).
    assign adr_full = (state_q == S_ADDR) ? {rx_data, adr_sh_q[31:8]} : adr_sh_q;
    assign dat_full = (state_q == S_DATA) ? {rx_data, dat_sh_q[31:8]} : dat_sh_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        adr_sh_d   = adr_sh_q;
        dat_sh_d   = dat_sh_q;
        is_wr_d    = is_wr_q;
        resp_d     = resp_q;
        tx_valid_d = tx_valid_q;
        mem_op_d   = mem_op_q;
        wren_d     = wren_q;
        adr_d      = adr_q;
        do_d       = do_q;
        cpu_d      = cpu_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    tx_valid_d = 1'b1;
                    cnt_d      = 32'd1;
                    state_d    = S_RESP;
                    case (rx_data)
                        CMD_H: begin
                            cpu_d  = 1'b0;
                            resp_d = {24'h0, ACK};
                        end
                        CMD_G: begin
                            cpu_d  = 1'b1;
                            resp_d = {24'h0, ACK};
                        end
                        CMD_W, CMD_R: begin
                            tx_valid_d = 1'b0;
                            cnt_d      = '0;
                            is_wr_d    = (rx_data == CMD_W);
                            state_d    = S_ADDR;
                        end
                        default: resp_d = {24'h0, NAK};
                    endcase
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_valid) begin
                    cnt_d = cnt_q + 32'd1;
                    if (state_q == S_ADDR) adr_sh_d = adr_full;
                    else                   dat_sh_d = dat_full;
                    if (cnt_q == 32'd3) begin
                        cnt_d = '0;
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_DATA;
                        end else if (cpu_q) begin
                            state_d    = S_RESP;
                            tx_valid_d = 1'b1;
                            cnt_d      = 32'd1;
                            resp_d     = {24'h0, NAK};
                        end else begin
                            state_d  = S_MEM;
                            mem_op_d = 1'b1;
                            wren_d   = is_wr_q ? 4'hF : 4'h0;
                            adr_d    = {adr_full[31:2], 2'b00};
                            if (is_wr_q) do_d = dat_full;
                        end
                    end
                end else if (TIMEOUT != 0 && tmo_q >= TIMEOUT - 1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_MEM: begin
                cnt_d = cnt_q + 32'd1;
                if (is_wr_q) begin
                    if (cnt_q == WR_CYCLES - 1) begin
                        mem_op_d   = 1'b0;
                        wren_d     = 4'h0;
                        resp_d     = {24'h0, ACK};
                        cnt_d      = 32'd1;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end
                end else if (cnt_q == RD_LAT - 1) begin
                    mem_op_d   = 1'b0;
                    resp_d     = dbg_di;
                    cnt_d      = 32'd4;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    resp_d = {8'h00, resp_q[31:8]};
                    cnt_d  = cnt_q - 32'd1;
                    if (cnt_q == 32'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            adr_sh_q   <= '0;
            dat_sh_q   <= '0;
            is_wr_q    <= 1'b0;
            resp_q     <= '0;
            tx_valid_q <= 1'b0;
            mem_op_q   <= 1'b0;
            wren_q     <= '0;
            adr_q      <= '0;
            do_q       <= '0;
            cpu_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            adr_sh_q   <= adr_sh_d;
            dat_sh_q   <= dat_sh_d;
            is_wr_q    <= is_wr_d;
            resp_q     <= resp_d;
            tx_valid_q <= tx_valid_d;
            mem_op_q   <= mem_op_d;
            wren_q     <= wren_d;
            adr_q      <= adr_d;
            do_q       <= do_d;
            cpu_q      <= cpu_d;
        end
    end

    assign tx_data     = resp_q[7:0];
    assign tx_valid    = tx_valid_q;
    assign dbg_mem_op  = mem_op_q;
    assign dbg_wren    = wren_q;
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign cpu_n_reset = cpu_q;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Bench for uart_dbg_loader: directed scenarios plus random commands checked
// against a command-level model of the host protocol and memory contents.
module tb_uart_dbg_loader;

    localparam int unsigned WRC = 3;
    localparam int unsigned RDL = 2;
    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        cpu_n_reset;

    logic [31:0] soc_mem [256];
    logic [31:0] exp_mem [256];

    uart_dbg_loader #(.WR_CYCLES(WRC), .RD_LAT(RDL), .TIMEOUT(TMO)) dut (
        .clk(clk), .n_reset(n_reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
        .dbg_do(dbg_do), .dbg_di(dbg_di), .cpu_n_reset(cpu_n_reset)
    );

    always #5 clk = ~clk;

    assign dbg_di = (dbg_mem_op && dbg_wren == 4'h0) ? soc_mem[dbg_adr[9:2]] : 32'h0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  wren;
        int          cyc;
        bit          stable;
    } bus_t;

    logic [7:0] txq [$];
    bus_t       busq [$];
    bus_t       cur;
    bit         in_op = 1'b0;

    // Observers sample 3 time units after the falling edge, well clear of the rising edge.
    always @(negedge clk) begin
        #3;
        if (!n_reset) begin
            in_op = 1'b0;
        end else begin
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (dbg_mem_op) begin
                if (!in_op) begin
                    cur.adr = dbg_adr; cur.dat = dbg_do; cur.wren = dbg_wren;
                    cur.cyc = 0; cur.stable = 1'b1; in_op = 1'b1;
                end else if (dbg_adr !== cur.adr || dbg_do !== cur.dat || dbg_wren !== cur.wren) begin
                    cur.stable = 1'b0;
                end
                cur.cyc++;
            end else if (in_op) begin
                in_op = 1'b0;
                busq.push_back(cur);
                if (cur.wren == 4'hF) soc_mem[cur.adr[9:2]] = cur.dat;
            end
        end
    end

    bit          cpu_run = 1'b0;
    logic [31:0] last_do = 32'h0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap = 1'b1);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (gap) tick($urandom_range(0, 3));
    endtask

    task automatic send_fields(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        send_byte(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int unsigned i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (cmd == 8'h57)
            for (int unsigned i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                           input logic [31:0] d, input bit rnd_ready);
        logic [7:0]  exp_tx [$];
        bit          exp_bus;
        bus_t        eb;
        logic [31:0] w;
        exp_bus = 1'b0;
        eb.adr = {a[31:2], 2'b00}; eb.dat = 32'h0; eb.wren = 4'h0; eb.cyc = 0; eb.stable = 1'b1;
        txq.delete();
        busq.delete();
        case (cmd)
            8'h48: begin cpu_run = 1'b0; exp_tx.push_back(8'h06); end
            8'h47: begin cpu_run = 1'b1; exp_tx.push_back(8'h06); end
            8'h57: begin
                if (cpu_run) exp_tx.push_back(8'h15);
                else begin
                    exp_bus = 1'b1; eb.dat = d; eb.wren = 4'hF; eb.cyc = WRC;
                    exp_mem[a[9:2]] = d; last_do = d;
                    exp_tx.push_back(8'h06);
                end
            end
            8'h52: begin
                if (cpu_run) exp_tx.push_back(8'h15);
                else begin
                    exp_bus = 1'b1; eb.dat = last_do; eb.wren = 4'h0; eb.cyc = RDL;
                    w = exp_mem[a[9:2]];
                    for (int unsigned i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
                end
            end
            default: exp_tx.push_back(8'h15);
        endcase
        send_fields(cmd, a, d);
        for (int k = 0; k < 3000 && txq.size() < exp_tx.size(); k++) begin
            @(negedge clk);
            tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        tx_ready = 1'b1;
        tick(10);
        chk({tag, "_ntx"}, txq.size(), exp_tx.size());
        for (int unsigned i = 0; i < exp_tx.size(); i++)
            if (i < txq.size()) chk({tag, "_tx"}, {24'h0, txq[i]}, {24'h0, exp_tx[i]});
        chk({tag, "_nbus"}, busq.size(), {31'h0, exp_bus});
        if (exp_bus && busq.size() > 0) begin
            chk({tag, "_adr"},    busq[0].adr, eb.adr);
            chk({tag, "_do"},     busq[0].dat, eb.dat);
            chk({tag, "_wren"},   {28'h0, busq[0].wren}, {28'h0, eb.wren});
            chk({tag, "_cyc"},    busq[0].cyc, eb.cyc);
            chk({tag, "_stable"}, {31'h0, busq[0].stable}, 32'h1);
            chk({tag, "_adrhold"}, dbg_adr, eb.adr);
        end
        chk({tag, "_cpu"}, {31'h0, cpu_n_reset}, {31'h0, cpu_run});
    endtask

    initial begin
        int          bad;
        logic [7:0]  held;
        logic [7:0]  r3 [4];
        logic [7:0]  oth;
        int unsigned sel;

        for (int unsigned i = 0; i < 256; i++) begin
            soc_mem[i] = $urandom;
            exp_mem[i] = soc_mem[i];
        end

        tick(3);
        chk("rst_cpu",   {31'h0, cpu_n_reset}, 32'h0);
        chk("rst_op",    {31'h0, dbg_mem_op}, 32'h0);
        chk("rst_wren",  {28'h0, dbg_wren}, 32'h0);
        chk("rst_adr",   dbg_adr, 32'h0);
        chk("rst_do",    dbg_do, 32'h0);
        chk("rst_txv",   {31'h0, tx_valid}, 32'h0);
        chk("rst_txd",   {24'h0, tx_data}, 32'h0);
        n_reset = 1'b1;

        // T1: idle after reset
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cpu_n_reset !== 1'b0 || dbg_mem_op !== 1'b0 || tx_valid !== 1'b0) bad++;
        end
        chk("T1_idle", bad, 0);

        // T2: halt then two writes
        run_cmd("T2_H",  8'h48, 32'h0, 32'h0, 1'b0);
        run_cmd("T2_W0", 8'h57, 32'h0002_0000, 32'h0000_006F, 1'b0);
        run_cmd("T2_W1", 8'h57, 32'h0002_0004, 32'h0000_0001, 1'b0);
        run_cmd("T2_R1", 8'h52, 32'h0002_0004, 32'h0, 1'b0);

        // T3: read with a long stall after the first reply byte
        soc_mem[0] = 32'hDEAD_BEEF;
        exp_mem[0] = 32'hDEAD_BEEF;
        txq.delete();
        busq.delete();
        send_fields(8'h52, 32'h0002_0000, 32'h0);
        for (int k = 0; k < 500 && txq.size() < 1; k++) @(negedge clk);
        tx_ready = 1'b0;
        held = tx_data;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            #3;
            if (tx_valid !== 1'b1 || tx_data !== held) bad++;
        end
        chk("T3_stall_stable", bad, 0);
        chk("T3_stall_byte", {24'h0, held}, 32'h0000_00BE);
        tx_ready = 1'b1;
        for (int k = 0; k < 500 && txq.size() < 4; k++) @(negedge clk);
        tick(10);
        chk("T3_ntx", txq.size(), 4);
        r3[0] = 8'hEF; r3[1] = 8'hBE; r3[2] = 8'hAD; r3[3] = 8'hDE;
        for (int unsigned i = 0; i < 4; i++)
            if (i < txq.size()) chk("T3_tx", {24'h0, txq[i]}, {24'h0, r3[i]});
        chk("T3_nbus", busq.size(), 1);

        // T4: CPU running, memory commands refused
        run_cmd("T4_G", 8'h47, 32'h0, 32'h0, 1'b0);
        run_cmd("T4_W", 8'h57, 32'h0002_0008, 32'h1234_5678, 1'b0);
        run_cmd("T4_R", 8'h52, 32'h0002_0008, 32'h0, 1'b0);
        run_cmd("T4_H", 8'h48, 32'h0, 32'h0, 1'b0);

        // T5: partial command then silence
        txq.delete();
        busq.delete();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        tick(TMO + 100);
        chk("T5_ntx", txq.size(), 0);
        chk("T5_nbus", busq.size(), 0);
        run_cmd("T5_H", 8'h48, 32'h0, 32'h0, 1'b0);

        // Random command mix
        for (int unsigned n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: run_cmd("RND_H", 8'h48, 32'h0, 32'h0, 1'b1);
                1: run_cmd("RND_G", 8'h47, 32'h0, 32'h0, 1'b1);
                2, 3, 4, 5: run_cmd("RND_W", 8'h57, 32'h0002_0000 | $urandom_range(0, 1023), $urandom, 1'b1);
                6, 7, 8: run_cmd("RND_R", 8'h52, 32'h0002_0000 | $urandom_range(0, 1023), 32'h0, 1'b1);
                default: begin
                    oth = 8'($urandom);
                    while (oth == 8'h48 || oth == 8'h47 || oth == 8'h57 || oth == 8'h52) oth = 8'($urandom);
                    run_cmd("RND_X", oth, 32'h0, 32'h0, 1'b1);
                end
            endcase
        end

        // T6: reset during a write bus cycle
        run_cmd("T6_H", 8'h48, 32'h0, 32'h0, 1'b0);
        send_byte(8'h57);
        for (int unsigned i = 0; i < 4; i++) send_byte(8'(32'h0002_0010 >> (8*i)));
        for (int unsigned i = 0; i < 3; i++) send_byte(8'(32'hCAFE_F00D >> (8*i)));
        send_byte(8'hCA, 1'b0);
        for (int k = 0; k < 20 && dbg_mem_op !== 1'b1; k++) @(negedge clk);
        chk("T6_op_seen", {31'h0, dbg_mem_op}, 32'h1);
        tick(1);
        n_reset = 1'b0;
        #1;
        chk("T6_op",   {31'h0, dbg_mem_op}, 32'h0);
        chk("T6_wren", {28'h0, dbg_wren}, 32'h0);
        chk("T6_txv",  {31'h0, tx_valid}, 32'h0);
        chk("T6_cpu",  {31'h0, cpu_n_reset}, 32'h0);
        chk("T6_adr",  dbg_adr, 32'h0);
        tick(2);
        n_reset = 1'b1;
        cpu_run = 1'b0;
        last_do = 32'h0;
        run_cmd("T6_after_H", 8'h48, 32'h0, 32'h0, 1'b0);
        run_cmd("T6_after_R", 8'h52, 32'h0002_0010, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
